fifo_rptr_read_port: RTL and testbench
======================================

Name: fifo_rptr_read_port

Overview:
Read-domain controller for the asynchronous FIFO. It sits in the read clock domain beside the dual-port FIFO memory. It owns the binary/Gray read pointer and drives the memory read address. It synchronises the write-domain Gray pointer, generates empty, almost-empty and fill-count status, and presents the head word through a registered show-ahead valid/ready output stage.

Parameters:
DATASIZE, 8, data word width in bits
ADDRSIZE, 4, memory address width; depth = 2^ADDRSIZE; pointers are ADDRSIZE+1 bits
ALMOST_EMPTY_LEVEL, 2, ralmost_empty asserts when rcount <= this value (range 0..2^ADDRSIZE)

Ports:
rclk  input  1  read-domain clock; all state updates on rising edge
rrst_n  input  1  asynchronous active-low reset, read domain
wptr_gray  input  ADDRSIZE+1  write pointer in Gray code, driven from the write clock domain (asynchronous to rclk)
rdata_mem  input  DATASIZE  combinational read data from memory at raddr
raddr  output  ADDRSIZE  memory read address = rbin[ADDRSIZE-1:0]
rptr_gray  output  ADDRSIZE+1  registered Gray read pointer, sent to the write domain
rempty  output  1  registered; 1 = no unread word remains in memory (the output register is not counted)
ralmost_empty  output  1  rcount <= ALMOST_EMPTY_LEVEL
rcount  output  ADDRSIZE+1  unread words in memory as seen by the read domain
rd_data  output  DATASIZE  head-of-FIFO word, registered
rd_valid  output  1  rd_data holds a valid word
rd_ready  input  1  consumer accepts rd_data this cycle

Behaviour:
- Reset (rrst_n=0, asynchronous, overrides everything):
  - sync flops rq1, rq2 = 0; rbin = 0; rptr_gray = 0; raddr = 0
  - rempty = 1; rd_valid = 0; rd_data = 0; rcount = 0; ralmost_empty = 1
  - Reset mid-operation discards rd_data and all pointers immediately.
  - The write domain must be reset in the same event.
- Synchroniser: two-flop chain wptr_gray -> rq1 -> rq2 on rclk. No other logic reads rq1.
- Pointers:
  - pop = rd_valid & rd_ready
  - load = !rempty & (!rd_valid | rd_ready)
  - rbinnext = rbin + load, modulo 2^(ADDRSIZE+1)
  - rgraynext = (rbinnext >> 1) ^ rbinnext
  - rbin and rptr_gray register rbinnext and rgraynext each edge.
- Empty: rempty <= (rgraynext == rq2), registered.
- Output stage, evaluated at each edge:
  - load: rd_data <= rdata_mem (word at current raddr), rd_valid <= 1.
  - pop and no load: rd_valid <= 0; rd_data holds its last value.
  - Otherwise rd_data and rd_valid hold.
  - rd_valid=1 & rd_ready=0 -> rd_data stays stable until accepted.
  - rd_ready while rd_valid=0 is ignored.
- Throughput: pop and load in the same cycle is allowed (1 word per rclk), rd_valid stays 1.
- Latency: wptr_gray change sampled at edge E -> rq2 updated at E+1 -> rempty=0 after E+2 -> rd_valid=1 with data after E+3.
- Count:
  - wbin_s = Gray-to-binary(rq2), combinational
  - rcount = (wbin_s - rbin) mod 2^(ADDRSIZE+1)
  - ralmost_empty = (rcount <= ALMOST_EMPTY_LEVEL)
  - Both are combinational from registers, so they carry no reset-time glitch.
- Wrap-around:
  - raddr wraps from DEPTH-1 to 0.
  - The pointer MSB toggles every DEPTH reads; Gray sequencing stays one-bit-change across the wrap.
- rcount never exceeds 2^ADDRSIZE for a legal write side.
- No underflow path: load is gated by rempty, so the read pointer never passes rq2.

Test Plan:
1. Reset: assert rrst_n=0 mid-clock -> immediately rempty=1, rd_valid=0, rd_data=0, raddr=0, rptr_gray=0, rcount=0, ralmost_empty=1.
2. Single word: memory[0]=8'hA5, wptr_gray 0->1 at edge E, rd_ready=0 -> rempty=0 after E+2, rd_valid=1 and rd_data=A5 after E+3. rempty returns to 1 after E+3 and raddr=1; rd_data is held for 10 idle cycles.
3. Full burst, 16 words 0x00..0x0F, wptr_gray=Gray(16)=5'b11000, rd_ready=1 -> rd_data 00..0F on 16 consecutive cycles. raddr wraps 15->0, rptr_gray ends at 5'b11000, rcount counts 16->0, rempty=1.
4. Backpressure: 4 words queued, rd_ready toggles 1,0,0,1,... -> each word is presented until accepted, no loss or duplication, order preserved.
5. Almost-empty, ALMOST_EMPTY_LEVEL=2: rcount=5 -> ralmost_empty=0; drain to rcount=2 -> ralmost_empty=1 in the same cycle rcount reaches 2.
6. Pointer wrap plus reset: stream 40 words through (rbin wraps past 31), check Gray one-bit steps each pop. Then assert rrst_n mid-burst -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/fifo_rptr_read_port.sv
// Read-domain side of the asynchronous FIFO: read pointer, write-pointer synchroniser,
// empty/level status and a registered show-ahead output stage.
module fifo_rptr_read_port #(
  parameter int DATASIZE           = 8,
  parameter int ADDRSIZE           = 4,
  parameter int ALMOST_EMPTY_LEVEL = 2
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic [ADDRSIZE:0]   wptr_gray,
  input  logic [DATASIZE-1:0] rdata_mem,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr_gray,
  output logic                rempty,
  output logic                ralmost_empty,
  output logic [ADDRSIZE:0]   rcount,
  output logic [DATASIZE-1:0] rd_data,
  output logic                rd_valid,
  input  logic                rd_ready
);

  function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
    logic [ADDRSIZE:0] b;
    b[ADDRSIZE] = g[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [ADDRSIZE:0] rq1, rq2;
  logic [ADDRSIZE:0] rbin, rbinnext, rgraynext, wbin_s;
  logic              load, pop;

  // Two-flop synchroniser for the write pointer crossing into rclk
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rq1 <= '0;
      rq2 <= '0;
    end else begin
      rq1 <= wptr_gray;
      rq2 <= rq1;
    end
  end

  always_comb begin
    pop       = rd_valid & rd_ready;
    load      = !rempty & (!rd_valid | rd_ready);
    rbinnext  = rbin + (ADDRSIZE + 1)'(load);
    rgraynext = (rbinnext >> 1) ^ rbinnext;
  end

  // Pointer, empty flag and show-ahead output register advance together
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin      <= '0;
      rptr_gray <= '0;
      rempty    <= 1'b1;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      rbin      <= rbinnext;
      rptr_gray <= rgraynext;
      rempty    <= (rgraynext == rq2);
      if (load) begin
        rd_data  <= rdata_mem;
        rd_valid <= 1'b1;
      end else if (pop) begin
        rd_valid <= 1'b0;
      end
    end
  end

  // Level status counts only words still in memory, not the one in rd_data
  always_comb begin
    wbin_s        = gray2bin(rq2);
    rcount        = wbin_s - rbin;
    ralmost_empty = (int'(rcount) <= ALMOST_EMPTY_LEVEL);
  end

  assign raddr = rbin[ADDRSIZE-1:0];

endmodule

// File: tb/tb_fifo_rptr_read_port.sv
// Randomised and directed bench for fifo_rptr_read_port with a word-sequence reference model.
module tb_fifo_rptr_read_port;
  localparam int DS  = 8;
  localparam int AS  = 4;
  localparam int AEL = 2;

  logic          rclk = 1'b0;
  logic          rrst_n = 1'b1;
  logic [AS:0]   wptr_gray = '0;
  logic [DS-1:0] rdata_mem;
  logic [AS-1:0] raddr;
  logic [AS:0]   rptr_gray;
  logic          rempty, ralmost_empty;
  logic [AS:0]   rcount;
  logic [DS-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready = 1'b0;

  fifo_rptr_read_port #(.DATASIZE(DS), .ADDRSIZE(AS), .ALMOST_EMPTY_LEVEL(AEL)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .wptr_gray(wptr_gray), .rdata_mem(rdata_mem),
    .raddr(raddr), .rptr_gray(rptr_gray), .rempty(rempty), .ralmost_empty(ralmost_empty),
    .rcount(rcount), .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready)
  );

  always #5 rclk = ~rclk;

  logic [DS-1:0] mem [16];
  assign rdata_mem = mem[raddr];

  int n_chk = 0;
  int n_fail = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] gray5(input int n);
    logic [4:0] b;
    b = 5'(n);
    return b ^ (b >> 1);
  endfunction

  // Write side: sequence-numbered words, memory slot = sequence mod 16
  int            wbin = 0;
  logic [DS-1:0] words [1024];

  task automatic push_word(input logic [DS-1:0] d);
    mem[wbin % 16] = d;
    words[wbin]    = d;
    wbin++;
    wptr_gray = gray5(wbin);
  endtask

  // Reference model in unbounded word counts: q1/q2 = writes seen through the
  // two-stage crossing, rd = words moved out of memory, pops = words consumed.
  int            m_q1 = 0, m_q2 = 0, m_rd = 0, m_pops = 0, m_nrd;
  bit            m_valid = 1'b0, m_empty = 1'b1, m_ld;
  logic [DS-1:0] m_data = '0;

  always @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      m_q1 = 0; m_q2 = 0; m_rd = 0; m_pops = 0;
      m_valid = 1'b0; m_empty = 1'b1; m_data = '0;
    end else begin
      m_ld = !m_empty && (!m_valid || rd_ready);
      if (m_valid && rd_ready) m_pops++;
      if (m_ld) begin
        m_data  = words[m_rd];
        m_valid = 1'b1;
      end else if (m_valid && rd_ready) begin
        m_valid = 1'b0;
      end
      m_nrd   = m_rd + (m_ld ? 1 : 0);
      m_empty = (m_nrd == m_q2);
      m_rd    = m_nrd;
      m_q2    = m_q1;
      m_q1    = wbin;
    end
  end

  logic [4:0] prev_g;
  bit         prev_ok = 1'b0;

  always @(negedge rclk) begin
    if (check_en) begin
      chk("rd_valid", rd_valid, m_valid);
      chk("rd_data", rd_data, m_data);
      chk("rempty", rempty, m_empty);
      chk("rcount", rcount, 32'(m_q2 - m_rd));
      chk("ralmost_empty", ralmost_empty, ((m_q2 - m_rd) <= AEL));
      chk("raddr", raddr, 32'(m_rd % 16));
      chk("rptr_gray", rptr_gray, gray5(m_rd));
      if (!rrst_n) begin
        prev_ok = 1'b0;
      end else begin
        if (prev_ok && rptr_gray != prev_g) chk("gray_step", $countones(prev_g ^ rptr_gray), 1);
        prev_g  = rptr_gray;
        prev_ok = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge rclk);
    @(negedge rclk);
  endtask

  task automatic do_reset();
    @(posedge rclk);
    #3;
    rrst_n = 1'b0;
    wbin = 0;
    wptr_gray = '0;
    rd_ready = 1'b0;
    #1;
    chk("rst_rempty", rempty, 1);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_raddr", raddr, 0);
    chk("rst_rptr_gray", rptr_gray, 0);
    chk("rst_rcount", rcount, 0);
    chk("rst_ralmost_empty", ralmost_empty, 1);
    repeat (2) @(negedge rclk);
    @(posedge rclk);
    #2 rrst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    for (int i = 0; i < 16; i++) mem[i] = '0;

    do_reset();
    check_en = 1'b1;

    // Single word: latency and hold under rd_ready=0
    @(negedge rclk);
    mem[0] = 8'h00;
    push_word(8'hA5);
    tick();
    chk("sw_empty_e0", rempty, 1);
    tick();
    chk("sw_empty_e1", rempty, 1);
    tick();
    chk("sw_empty_e2", rempty, 0);
    chk("sw_valid_e2", rd_valid, 0);
    tick();
    chk("sw_valid_e3", rd_valid, 1);
    chk("sw_data_e3", rd_data, 8'hA5);
    chk("sw_empty_e3", rempty, 1);
    chk("sw_raddr_e3", raddr, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("sw_hold_data", rd_data, 8'hA5);
      chk("sw_hold_valid", rd_valid, 1);
    end
    rd_ready = 1'b1;
    tick();
    chk("sw_popped", rd_valid, 0);
    rd_ready = 1'b0;

    // Full burst of 16 words
    do_reset();
    @(negedge rclk);
    for (int i = 0; i < 16; i++) push_word(8'(i));
    chk("burst_wgray", wptr_gray, 5'b11000);
    rd_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      found = rd_valid;
    end
    chk("burst_wait", found, 1);
    for (int i = 0; i < 16; i++) begin
      chk("burst_data", rd_data, i);
      chk("burst_valid", rd_valid, 1);
      if (i < 15) tick();
    end
    chk("burst_rptr_gray", rptr_gray, 5'b11000);
    chk("burst_raddr", raddr, 0);
    chk("burst_rcount", rcount, 0);
    chk("burst_rempty", rempty, 1);
    tick();
    rd_ready = 1'b0;

    // Backpressure with ready pattern 1,0,0,1
    do_reset();
    @(negedge rclk);
    for (int i = 0; i < 4; i++) push_word(8'($urandom));
    for (int i = 0; i < 24; i++) begin
      rd_ready = (i % 4 == 0) || (i % 4 == 3);
      tick();
    end
    chk("bp_drained", m_pops, 4);
    rd_ready = 1'b0;

    // Almost-empty threshold
    do_reset();
    @(negedge rclk);
    for (int i = 0; i < 5; i++) push_word(8'(8'h50 + i));
    tick();
    tick();
    chk("ae_rcount5", rcount, 5);
    chk("ae_at5", ralmost_empty, 0);
    rd_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (rcount == 3) chk("ae_at3", ralmost_empty, 0);
      if (rcount == 2) begin
        chk("ae_at2", ralmost_empty, 1);
        found = 1'b1;
      end
    end
    chk("ae_reach2", found, 1);
    repeat (8) tick();
    rd_ready = 1'b0;

    // Random streaming across several pointer wraps
    do_reset();
    @(negedge rclk);
    for (int c = 0; c < 400; c++) begin
      if (($urandom % 4) != 0 && (wbin - m_pops) < 16 && wbin < 300) push_word(8'($urandom));
      rd_ready = 1'($urandom % 2);
      tick();
    end
    chk("stream_wrapped", (m_rd >= 40), 1);

    // Keep streaming, then reset mid-burst
    for (int c = 0; c < 12; c++) begin
      if ((wbin - m_pops) < 16 && wbin < 1000) push_word(8'($urandom));
      rd_ready = 1'($urandom % 2);
      tick();
    end
    do_reset();
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
